// File: rtl/reg_wb_arbiter_if.sv
// Bus bundle between the write-side arbiter and its producers/consumer.
// The master side drives the requests; the slave side is the arbiter.
interface reg_wb_arbiter_if;
  logic        pipe_we;
  logic [4:0]  pipe_wa;
  logic [31:0] pipe_wd;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_wa;
  logic [31:0] lu_wd;
  logic        issue_valid;
  logic [4:0]  issue_wa;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] busy;
  logic        err;

  modport master (
    output pipe_we, pipe_wa, pipe_wd, lu_valid, lu_wa, lu_wd, issue_valid, issue_wa,
    input  lu_ready, we, wa, wd, busy, err
  );

  modport slave (
    input  pipe_we, pipe_wa, pipe_wd, lu_valid, lu_wa, lu_wd, issue_valid, issue_wa,
    output lu_ready, we, wa, wd, busy, err
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Merges pipeline writeback and buffered long-latency results onto the single
// register file write port, and tracks pending long-latency destinations.
module reg_wb_arbiter (
  input  logic              clk,
  input  logic              rst,
  reg_wb_arbiter_if.slave   bus
);

  logic [1:0]  count_q, count_d;
  logic        rptr_q, rptr_d;
  logic        wptr_q, wptr_d;
  logic [4:0]  mem_wa_q [2];
  logic [31:0] mem_wd_q [2];

  logic        we_q, we_d;
  logic [4:0]  wa_q, wa_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] busy_q, busy_d;
  logic        err_q, err_d;

  logic        lu_ready;
  logic        push, pop, pipe_eff;
  logic [4:0]  head_wa;
  logic [31:0] head_wd;

  // Ready depends only on the registered count, never on this cycle's requests.
  assign lu_ready = (count_q != 2'd2);
  assign push     = bus.lu_valid & lu_ready;
  assign pipe_eff = bus.pipe_we & (bus.pipe_wa != 5'd0);
  assign pop      = ~pipe_eff & (count_q != 2'd0);
  assign head_wa  = mem_wa_q[rptr_q];
  assign head_wd  = mem_wd_q[rptr_q];

  always_comb begin
    count_d = count_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    busy_d  = busy_q;
    err_d   = err_q;

    if (push) wptr_d = ~wptr_q;
    if (pop)  rptr_d = ~rptr_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;

    if (pipe_eff) begin
      we_d = 1'b1;
      wa_d = bus.pipe_wa;
      wd_d = bus.pipe_wd;
      if (busy_q[bus.pipe_wa]) err_d = 1'b1;
    end else if (pop) begin
      // A result for register 0 is drained but never written.
      we_d = (head_wa != 5'd0);
      wa_d = head_wa;
      wd_d = head_wd;
      busy_d[head_wa] = 1'b0;
      if (!busy_q[head_wa] && head_wa != 5'd0) err_d = 1'b1;
    end

    // Applied after the clear so a same-cycle set wins.
    if (bus.issue_valid) begin
      busy_d[bus.issue_wa] = 1'b1;
      if (busy_q[bus.issue_wa]) err_d = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      rptr_q  <= 1'b0;
      wptr_q  <= 1'b0;
      we_q    <= 1'b0;
      wa_q    <= 5'd0;
      wd_q    <= 32'd0;
      busy_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_wa_q[wptr_q] <= bus.lu_wa;
      mem_wd_q[wptr_q] <= bus.lu_wd;
    end
  end

  assign bus.lu_ready = lu_ready;
  assign bus.we       = we_q;
  assign bus.wa       = wa_q;
  assign bus.wd       = wd_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: inputs change 1ns after each rising edge,
// outputs are checked at that same point, reflecting the previous cycle's inputs.
module tb_reg_wb_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  reg_wb_arbiter_if bus ();

  reg_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pipe_we     = 1'b0;
    bus.pipe_wa     = 5'd0;
    bus.pipe_wd     = 32'd0;
    bus.lu_valid    = 1'b0;
    bus.lu_wa       = 5'd0;
    bus.lu_wd       = 32'd0;
    bus.issue_valid = 1'b0;
    bus.issue_wa    = 5'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [4:0] r);
    bus.issue_valid = 1'b1;
    bus.issue_wa    = r;
    tick();
    bus.issue_valid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    #1;
    do_reset();
    check("rst_we", 32'(bus.we), 32'd0);
    check("rst_wa", 32'(bus.wa), 32'd0);
    check("rst_wd", bus.wd, 32'd0);
    check("rst_busy", bus.busy, 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_ready", 32'(bus.lu_ready), 32'd1);

    // Pipeline write
    bus.pipe_we = 1'b1; bus.pipe_wa = 5'd5; bus.pipe_wd = 32'hDEADBEEF;
    tick();
    bus.pipe_we = 1'b0;
    check("pipe_we", 32'(bus.we), 32'd1);
    check("pipe_wa", 32'(bus.wa), 32'd5);
    check("pipe_wd", bus.wd, 32'hDEADBEEF);
    tick();
    check("idle_we", 32'(bus.we), 32'd0);
    check("idle_wa_hold", 32'(bus.wa), 32'd5);

    // Long-latency write: issue at N, handshake at N+3, write at N+5
    issue(5'd9);
    check("ll_busy_n1", bus.busy, 32'h0000_0200);
    tick();
    tick();
    check("ll_busy_n3", bus.busy, 32'h0000_0200);
    bus.lu_valid = 1'b1; bus.lu_wa = 5'd9; bus.lu_wd = 32'h1234;
    tick();
    bus.lu_valid = 1'b0;
    check("ll_busy_n4", bus.busy, 32'h0000_0200);
    check("ll_we_n4", 32'(bus.we), 32'd0);
    tick();
    check("ll_we", 32'(bus.we), 32'd1);
    check("ll_wa", 32'(bus.wa), 32'd9);
    check("ll_wd", bus.wd, 32'h1234);
    check("ll_busy_clr", bus.busy, 32'd0);
    check("ll_err", 32'(bus.err), 32'd0);

    // Back-pressure under continuous pipeline writes
    issue(5'd10);
    issue(5'd11);
    bus.pipe_we = 1'b1; bus.pipe_wa = 5'd3; bus.pipe_wd = 32'h33;
    bus.lu_valid = 1'b1; bus.lu_wa = 5'd10; bus.lu_wd = 32'hA0;
    tick();
    check("bp_ready1", 32'(bus.lu_ready), 32'd1);
    bus.lu_wa = 5'd11; bus.lu_wd = 32'hB0;
    tick();
    check("bp_ready2", 32'(bus.lu_ready), 32'd0);
    bus.lu_wa = 5'd12; bus.lu_wd = 32'hC0;
    tick();
    check("bp_ready3", 32'(bus.lu_ready), 32'd0);
    check("bp_pipe_wa", 32'(bus.wa), 32'd3);
    bus.lu_valid = 1'b0;
    bus.pipe_we  = 1'b0;
    tick();
    check("bp_pop1_we", 32'(bus.we), 32'd1);
    check("bp_pop1_wa", 32'(bus.wa), 32'd10);
    check("bp_pop1_wd", bus.wd, 32'hA0);
    check("bp_ready_back", 32'(bus.lu_ready), 32'd1);
    tick();
    check("bp_pop2_wa", 32'(bus.wa), 32'd11);
    check("bp_pop2_wd", bus.wd, 32'hB0);
    check("bp_busy", bus.busy, 32'd0);
    tick();
    check("bp_third_dropped", 32'(bus.we), 32'd0);
    check("bp_err", 32'(bus.err), 32'd0);

    // pipe_wa == 0 leaves the slot to the buffer
    issue(5'd7);
    bus.lu_valid = 1'b1; bus.lu_wa = 5'd7; bus.lu_wd = 32'h55;
    tick();
    bus.lu_valid = 1'b0;
    bus.pipe_we = 1'b1; bus.pipe_wa = 5'd0; bus.pipe_wd = 32'h99;
    tick();
    bus.pipe_we = 1'b0;
    check("r0_pipe_we", 32'(bus.we), 32'd1);
    check("r0_pipe_wa", 32'(bus.wa), 32'd7);
    check("r0_pipe_wd", bus.wd, 32'h55);

    // Result for register 0 drains without a write
    bus.lu_valid = 1'b1; bus.lu_wa = 5'd0; bus.lu_wd = 32'h77;
    tick();
    bus.lu_valid = 1'b0;
    tick();
    check("r0_lu_we", 32'(bus.we), 32'd0);
    check("r0_lu_ready", 32'(bus.lu_ready), 32'd1);
    check("r0_lu_err", 32'(bus.err), 32'd0);

    // Double issue to reg 4 is a violation and stays sticky
    issue(5'd4);
    check("v_pre_err", 32'(bus.err), 32'd0);
    issue(5'd4);
    check("v_issue_err", 32'(bus.err), 32'd1);
    tick();
    tick();
    check("v_issue_sticky", 32'(bus.err), 32'd1);

    // Pipeline write to a busy register
    do_reset();
    issue(5'd4);
    bus.pipe_we = 1'b1; bus.pipe_wa = 5'd4; bus.pipe_wd = 32'h1;
    tick();
    bus.pipe_we = 1'b0;
    check("v_pipe_err", 32'(bus.err), 32'd1);
    check("v_pipe_wa", 32'(bus.wa), 32'd4);

    // Reset with two entries buffered discards them
    do_reset();
    issue(5'd20);
    issue(5'd21);
    bus.pipe_we = 1'b1; bus.pipe_wa = 5'd3; bus.pipe_wd = 32'h3;
    bus.lu_valid = 1'b1; bus.lu_wa = 5'd20; bus.lu_wd = 32'h20;
    tick();
    bus.lu_wa = 5'd21; bus.lu_wd = 32'h21;
    tick();
    check("mr_full", 32'(bus.lu_ready), 32'd0);
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_we", 32'(bus.we), 32'd0);
    check("mr_busy", bus.busy, 32'd0);
    check("mr_ready", 32'(bus.lu_ready), 32'd1);
    tick();
    check("mr_no_write1", 32'(bus.we), 32'd0);
    tick();
    check("mr_no_write2", 32'(bus.we), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
